// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU control path: sequencer states, latched
// instruction class, accumulator source and ALU op encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_OPERAND,
    ST_EXEC,
    ST_IN_WAIT,
    ST_OUT_WAIT,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    INS_NOP,
    INS_LOAD,
    INS_ADD,
    INS_SUB,
    INS_AND,
    INS_JUMP,
    INS_JZ,
    INS_JNZ,
    INS_JC,
    INS_JNC
  } instr_t;

  localparam logic [1:0] ACC_SEL_ALU = 2'd0;
  localparam logic [1:0] ACC_SEL_OPR = 2'd1;
  localparam logic [1:0] ACC_SEL_IN  = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;

  // Decoder strobe bundle order: ip, op, load, add, sub, and, jump, jz, jnz, jc, jnc
  function automatic logic dec_legal(input logic [10:0] v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/cpu_ctrl_timeout.sv
// Memory-wait counter: counts request cycles without an ack; expired is combinational
// and asserts on the MEM_TIMEOUT-th consecutive un-acked cycle.
module cpu_ctrl_timeout #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  assign expired = en && (cnt == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU sequencer; outputs decode from registered state plus handshake inputs,
// waits indefinitely on in_valid/out_ready, bounded by MEM_TIMEOUT on mem_ack. Macro: CTRL_ILLEGAL_TRAP_EN.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALU_OP_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_ip,
  input  logic                dec_op,
  input  logic                dec_load,
  input  logic                dec_add,
  input  logic                dec_sub,
  input  logic                dec_and,
  input  logic                dec_jump,
  input  logic                dec_jumpz,
  input  logic                dec_jumpnz,
  input  logic                dec_jumpc,
  input  logic                dec_jumpnc,
  input  logic                flag_z,
  input  logic                flag_c,
  input  logic                mem_ack,
  input  logic                in_valid,
  input  logic                out_ready,
  output logic                mem_req,
  output logic                ir_load,
  output logic                opr_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                acc_load,
  output logic [1:0]          acc_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                flags_load,
  output logic                in_ready,
  output logic                out_valid,
  output logic                halted,
  output logic                bus_err,
  output logic                illegal
);

  state_t state, state_nxt;
  instr_t instr_q, instr_nxt;
  logic   bus_err_q, set_bus_err;
  logic   mem_wait, to_clr, to_en, to_expired;
  logic [10:0] dec_vec;

  assign dec_vec = {dec_ip, dec_op, dec_load, dec_add, dec_sub, dec_and,
                    dec_jump, dec_jumpz, dec_jumpnz, dec_jumpc, dec_jumpnc};

  // Counter runs only while a memory request is outstanding, so it is already
  // zero on every entry to FETCH or OPERAND.
  assign mem_wait = (state == ST_FETCH) || (state == ST_OPERAND);
  assign to_en    = mem_wait && !mem_ack;
  assign to_clr   = !mem_wait || mem_ack;

  cpu_ctrl_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, set_illegal;
`endif

  always_comb begin
    state_nxt   = state;
    instr_nxt   = instr_q;
    set_bus_err = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    set_illegal = 1'b0;
`endif
    mem_req     = 1'b0;
    ir_load     = 1'b0;
    opr_load    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    acc_load    = 1'b0;
    acc_sel     = ACC_SEL_ALU;
    alu_op      = ALU_OP_W'(ALU_ADD);
    flags_load  = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    halted      = 1'b0;

    case (state)
      ST_RST: state_nxt = ST_FETCH;

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = ST_DECODE;
        end else if (to_expired) begin
          set_bus_err = 1'b1;
          state_nxt   = ST_HALT;
        end
      end

      ST_DECODE: begin
        if (!dec_legal(dec_vec)) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          set_illegal = 1'b1;
          state_nxt   = ST_HALT;
`else
          state_nxt   = ST_FETCH;
`endif
        end else if (dec_ip) begin
          state_nxt = ST_IN_WAIT;
        end else if (dec_op) begin
          state_nxt = ST_OUT_WAIT;
        end else begin
          state_nxt = ST_OPERAND;
          if      (dec_load)   instr_nxt = INS_LOAD;
          else if (dec_add)    instr_nxt = INS_ADD;
          else if (dec_sub)    instr_nxt = INS_SUB;
          else if (dec_and)    instr_nxt = INS_AND;
          else if (dec_jump)   instr_nxt = INS_JUMP;
          else if (dec_jumpz)  instr_nxt = INS_JZ;
          else if (dec_jumpnz) instr_nxt = INS_JNZ;
          else if (dec_jumpc)  instr_nxt = INS_JC;
          else                 instr_nxt = INS_JNC;
        end
      end

      ST_OPERAND: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          opr_load  = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = ST_EXEC;
        end else if (to_expired) begin
          set_bus_err = 1'b1;
          state_nxt   = ST_HALT;
        end
      end

      ST_EXEC: begin
        state_nxt = ST_FETCH;
        case (instr_q)
          INS_LOAD: begin
            acc_load = 1'b1;
            acc_sel  = ACC_SEL_OPR;
          end
          INS_ADD, INS_SUB, INS_AND: begin
            acc_load   = 1'b1;
            flags_load = 1'b1;
            if (instr_q == INS_SUB)      alu_op = ALU_OP_W'(ALU_SUB);
            else if (instr_q == INS_AND) alu_op = ALU_OP_W'(ALU_AND);
          end
          INS_JUMP: pc_load = 1'b1;
          INS_JZ:   pc_load = flag_z;
          INS_JNZ:  pc_load = !flag_z;
          INS_JC:   pc_load = flag_c;
          INS_JNC:  pc_load = !flag_c;
          default:  ;
        endcase
      end

      ST_IN_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_load  = 1'b1;
          acc_sel   = ACC_SEL_IN;
          state_nxt = ST_FETCH;
        end
      end

      ST_OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_FETCH;
      end

      ST_HALT: halted = 1'b1;

      default: state_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST;
      instr_q   <= INS_NOP;
      bus_err_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      instr_q <= instr_nxt;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           illegal_q <= 1'b0;
    else if (set_illegal) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control sequencer for the 8-bit CPU. It consumes the one-hot strobes produced by the instruction decoder and the ALU flags, and steps the datapath through fetch, operand fetch, execute and I/O handshake phases. It drives every load and enable in the datapath: PC, instruction register, operand register, accumulator, ALU op select and flags. It sits between the decoder and the datapath.

## Interface
- MEM_TIMEOUT, 15: max cycles waiting for `mem_ack` before a bus error (1..255)
- ALU_OP_W, 2: width of `alu_op`
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_ip, dec_op, dec_load, dec_add, dec_sub, dec_and  in  1 each  decoder strobes: input, output, load-immediate, add, sub, bitand
- dec_jump, dec_jumpz, dec_jumpnz, dec_jumpc, dec_jumpnc  in  1 each  decoder jump strobes
- flag_z, flag_c  in  1  registered zero/carry flags from datapath
- mem_ack  in  1  program memory data valid for current `mem_req`
- in_valid  in  1  input port has data
- out_ready  in  1  output port accepts data
- mem_req  out  1  program memory read request, address = PC
- ir_load, opr_load  out  1  load instruction / operand register from memory data
- pc_inc, pc_load  out  1  PC+1 / PC := operand register
- acc_load  out  1  accumulator write enable
- acc_sel  out  2  accumulator source: 0 ALU, 1 operand, 2 input port
- alu_op  out  ALU_OP_W  0 add, 1 sub, 2 and
- flags_load  out  1  capture ALU zero/carry
- in_ready, out_valid  out  1  I/O port handshakes
- halted, bus_err, illegal  out  1  sticky status

## Operation
- States: RST, FETCH, DECODE, OPERAND, EXEC, IN_WAIT, OUT_WAIT, HALT.
- RST: all outputs 0. Unconditionally goes to FETCH on the next clock.
- FETCH: `mem_req`=1. On `mem_ack`: `ir_load`, `pc_inc` for that cycle, then DECODE.
- DECODE: samples `dec_*` for one cycle. If zero or more than one strobe is high, the instruction is illegal (see Configuration). `dec_ip` goes to IN_WAIT, `dec_op` to OUT_WAIT, and all others go to OPERAND. Every other instruction is two bytes and takes an immediate operand.
- OPERAND: `mem_req`=1. On `mem_ack`: `opr_load`, `pc_inc`, then EXEC.
- EXEC is one cycle, then FETCH:
  - load: `acc_load`, `acc_sel`=1
  - add/sub/and: `acc_load`, `acc_sel`=0, `alu_op`, `flags_load`
  - jump: `pc_load`
  - jumpz/jumpnz/jumpc/jumpnc: `pc_load` only when the condition on `flag_z`/`flag_c` holds in this cycle
- IN_WAIT: `in_ready`=1. On `in_valid`: `acc_load`, `acc_sel`=2, then FETCH.
- OUT_WAIT: `out_valid`=1. On `out_ready`: FETCH.
- Timeout counter: cleared on entry to FETCH/OPERAND and increments each cycle without `mem_ack`. When it reaches MEM_TIMEOUT: `bus_err`=1, then HALT. An ack in the same cycle wins.
- HALT is terminal: all strobes 0, `halted`=1. Exit only by reset.
- Asserting `rst_n` low at any time, including mid-handshake, immediately forces RST, all outputs 0 and status cleared.

## Timing
- All outputs are decoded from the registered state plus the current handshake inputs. Strobes are single-cycle pulses.
- Minimum cycles per instruction with zero-wait memory (`mem_ack` in the first request cycle):
  - ip/op: 3 (FETCH, DECODE, WAIT)
  - two-byte instructions: 4 (FETCH, DECODE, OPERAND, EXEC)
- `mem_req` stays high continuously until `mem_ack`; it never drops mid-wait.
- Taken jump: `pc_load` in EXEC; the next FETCH uses the new PC.
- Flags from an ALU op are visible to a conditional jump starting at the following instruction.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an illegal decode in DECODE sets `illegal`=1 and goes to HALT.
- CTRL_ILLEGAL_TRAP_EN undefined: an illegal decode is a one-byte NOP (DECODE goes to FETCH) and `illegal` is tied 0.

## Structure
- Shared package `cpu_pkg`: state enum, `acc_sel` encodings, `alu_op` encodings (ADD=0, SUB=1, AND=2).
- One sub-module: `cpu_ctrl_timeout`, the memory-wait counter with clear/enable/expired ports.

## Test plan
- Reset, then `mem_ack` tied 1 and decoder presenting load (imm 8'h5A) -> within 4 cycles `acc_load`=1 with `acc_sel`=1; `pc_inc` pulses twice.
- add, `mem_ack` 1 -> EXEC cycle shows `acc_load`=1, `acc_sel`=0, `alu_op`=0, `flags_load`=1.
- jumpz with `flag_z`=0, then again with `flag_z`=1 -> `pc_load` 0 then 1; jump and jumpnc give the expected results with `flag_c`=0.
- ip with `in_valid` held low for 5 cycles, then high -> `in_ready` high for 6 cycles, `acc_load` with `acc_sel`=2 in the last one. op with `out_ready` delayed behaves symmetrically.
- `mem_ack` never asserted -> `bus_err`=1 and `halted`=1 after 15 FETCH cycles. Reset mid-wait clears both and outputs return to 0 immediately.
- Two decoder strobes high -> with CTRL_ILLEGAL_TRAP_EN, `illegal`=1 and HALT; without it, FETCH follows DECODE with no datapath strobes.
